// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: width codes, FSM states,
// and the store lane-alignment helpers.
package mem_access_unit_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic is_half;
        is_half = (f3 == F3_H) || (f3 == F3_HU);
        return (is_half && off[0]) || ((f3 == F3_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << off;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables pick the right one.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B, F3_BU: d = {4{wd[7:0]}};
            F3_H, F3_HU: d = {2{wd[15:0]}};
            default:     d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data extraction: selects the addressed byte/half of the read word and
// sign- or zero-extends it to 32 bits.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted  = rdata_i >> {off_i, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = shifted[15:0];
        result_o = rdata_i;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result_o = {24'h000000, byte_v};
            F3_H:    result_o = {{16{half_v[15]}}, half_v};
            F3_HU:   result_o = {16'h0000, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns EX/MEM loads/stores into req/gnt/rvalid bus
// transactions, stalls the pipeline while busy, and aligns load data for writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_wb_load_valid,
    output logic [31:0] mem_wb_rdata,
    output logic        misalign_fault,
    output logic        access_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      addr_q, addr_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             load_valid_q, load_valid_d;
    logic             misalign_q, misalign_d;
    logic             afault_q, afault_d;
    logic [31:0]      aligned_rdata;
    logic             req_any;
    logic             timeout_hit;

    mem_access_unit_load_align u_load_align (
        .off_i    (off_q),
        .funct3_i (f3_q),
        .rdata_i  (dmem_rdata),
        .result_o (aligned_rdata)
    );

    assign req_any     = ex_mem_valid && (ex_mem_mem_read || ex_mem_mem_write);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, bus handshake and stall decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        off_d        = off_q;
        f3_d         = f3_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        afault_d     = 1'b0;
        dmem_req     = 1'b0;
        mem_stall    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if ((ex_mem_mem_read && ex_mem_mem_write) || !f3_legal(ex_mem_funct3)) begin
                        afault_d = 1'b1;
                    end else if (f3_misaligned(ex_mem_funct3, ex_mem_addr[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d    = ex_mem_addr[31:2];
                        off_d     = ex_mem_addr[1:0];
                        f3_d      = ex_mem_funct3;
                        we_d      = ex_mem_mem_write;
                        be_d      = store_be(ex_mem_funct3, ex_mem_addr[1:0]);
                        wdata_d   = store_wdata(ex_mem_funct3, ex_mem_wdata);
                        cnt_d     = '0;
                        mem_stall = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (dmem_gnt && we_q) begin
                    mem_stall = 1'b0;
                    state_d   = ST_IDLE;
                end else if (dmem_gnt && dmem_rvalid) begin
                    rdata_d      = aligned_rdata;
                    load_valid_d = 1'b1;
                    mem_stall    = 1'b0;
                    state_d      = ST_IDLE;
                end else if (timeout_hit) begin
                    afault_d  = 1'b1;
                    mem_stall = 1'b0;
                    state_d   = ST_IDLE;
                end else if (dmem_gnt) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (dmem_rvalid) begin
                    rdata_d      = aligned_rdata;
                    load_valid_d = 1'b1;
                    mem_stall    = 1'b0;
                    state_d      = ST_IDLE;
                end else if (timeout_hit) begin
                    afault_d  = 1'b1;
                    mem_stall = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            afault_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            afault_q     <= afault_d;
        end
    end

    assign dmem_we           = we_q;
    assign dmem_addr         = {addr_q, 2'b00};
    assign dmem_be           = be_q;
    assign dmem_wdata        = wdata_q;
    assign mem_wb_load_valid = load_valid_q;
    assign mem_wb_rdata      = rdata_q;
    assign misalign_fault    = misalign_q;
    assign access_fault      = afault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, faults, timeout and reset abort.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_valid = 1'b0;
    logic        ex_mem_mem_read = 1'b0;
    logic        ex_mem_mem_write = 1'b0;
    logic [2:0]  ex_mem_funct3 = 3'b000;
    logic [31:0] ex_mem_addr = 32'h0;
    logic [31:0] ex_mem_wdata = 32'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        mem_stall;
    logic        mem_wb_load_valid;
    logic [31:0] mem_wb_rdata;
    logic        misalign_fault;
    logic        access_fault;

    int vectors = 0;
    int miscompares = 0;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_mem_read   (ex_mem_mem_read),
        .ex_mem_mem_write  (ex_mem_mem_write),
        .ex_mem_funct3     (ex_mem_funct3),
        .ex_mem_addr       (ex_mem_addr),
        .ex_mem_wdata      (ex_mem_wdata),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_be           (dmem_be),
        .dmem_wdata        (dmem_wdata),
        .dmem_gnt          (dmem_gnt),
        .dmem_rvalid       (dmem_rvalid),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .mem_wb_load_valid (mem_wb_load_valid),
        .mem_wb_rdata      (mem_wb_rdata),
        .misalign_fault    (misalign_fault),
        .access_fault      (access_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd);
        ex_mem_valid     = 1'b1;
        ex_mem_mem_read  = rd;
        ex_mem_mem_write = wr;
        ex_mem_funct3    = f3;
        ex_mem_addr      = addr;
        ex_mem_wdata     = wd;
    endtask

    task automatic clear_access();
        ex_mem_valid     = 1'b0;
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_wb_load_valid,
             mem_wb_rdata, misalign_fault, access_fault} !== 104'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wd=%h stall=%b lv=%b rd=%h mf=%b af=%b, all required 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_wb_load_valid,
                     mem_wb_rdata, misalign_fault, access_fault);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    // SW 0x100, grant on the third request cycle.
    task automatic test_store_word();
        int  stall_cnt = 0;
        logic fault_seen = 1'b0;
        drive_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        if (mem_stall === 1'b1) stall_cnt++;
        step();
        clear_access();
        @(negedge clk);
        if (mem_stall === 1'b1) stall_cnt++;
        vectors++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL sw_bus: req=%b we=%b addr=%h be=%b wd=%h, required 1 1 00000100 1111 deadbeef",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        step();
        @(negedge clk);
        if (mem_stall === 1'b1) stall_cnt++;
        vectors++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL sw_req_held: req=%b addr=%h, required 1 00000100", dmem_req, dmem_addr);
        end
        step();
        dmem_gnt = 1'b1;
        @(negedge clk);
        if (mem_stall === 1'b1) stall_cnt++;
        fault_seen = misalign_fault | access_fault;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        fault_seen = fault_seen | misalign_fault | access_fault;
        vectors++;
        if (stall_cnt !== 3) begin
            miscompares++;
            $display("FAIL sw_stall_cycles: got %0d, required 3", stall_cnt);
        end
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || fault_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_done: req=%b stall=%b faults=%b, required 0 0 0", dmem_req, mem_stall, fault_seen);
        end
        step();
    endtask

    // SH 0x32 with grant on the first request cycle.
    task automatic test_store_half();
        drive_access(1'b0, 1'b1, 3'b001, 32'h0000_0032, 32'h1234_ABCD);
        @(negedge clk);
        step();
        clear_access();
        dmem_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, mem_stall} !== {1'b1, 32'h0000_0030, 4'b1100, 32'hABCD_ABCD, 1'b0}) begin
            miscompares++;
            $display("FAIL sh_bus: req=%b addr=%h be=%b wd=%h stall=%b, required 1 00000030 1100 abcdabcd 0",
                     dmem_req, dmem_addr, dmem_be, dmem_wdata, mem_stall);
        end
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_idle: req=%b, required 0", dmem_req);
        end
        step();
    endtask

    // LB/LBU 0x203, grant then rvalid one cycle later.
    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        drive_access(1'b1, 1'b0, f3, 32'h0000_0203, 32'h0);
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL lb_accept_stall: got %b, required 1", mem_stall);
        end
        step();
        clear_access();
        dmem_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, mem_stall} !== {1'b1, 1'b0, 32'h0000_0200, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL lb_bus: req=%b we=%b addr=%h be=%b stall=%b, required 1 0 00000200 1000 1",
                     dmem_req, dmem_we, dmem_addr, dmem_be, mem_stall);
        end
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_FFFF;
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b0 || mem_wb_load_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_rvalid_cycle: stall=%b lv=%b, required 0 0", mem_stall, mem_wb_load_valid);
        end
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        @(negedge clk);
        vectors++;
        if (mem_wb_load_valid !== 1'b1 || mem_wb_rdata !== exp) begin
            miscompares++;
            $display("FAIL lb_result f3=%b: lv=%b rdata=%h, required 1 %h", f3, mem_wb_load_valid, mem_wb_rdata, exp);
        end
        step();
        @(negedge clk);
        vectors++;
        if (mem_wb_load_valid !== 1'b0 || mem_wb_rdata !== exp) begin
            miscompares++;
            $display("FAIL lb_hold f3=%b: lv=%b rdata=%h, required 0 %h", f3, mem_wb_load_valid, mem_wb_rdata, exp);
        end
        step();
    endtask

    // Grant and rvalid in the same request cycle.
    task automatic test_load_direct(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] rdata, input logic [31:0] exp);
        drive_access(1'b1, 1'b0, f3, addr, 32'h0);
        @(negedge clk);
        step();
        clear_access();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_stall f3=%b: stall=%b req=%b, required 0 1", f3, mem_stall, dmem_req);
        end
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_wb_load_valid !== 1'b1 || mem_wb_rdata !== exp || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_result f3=%b: lv=%b rdata=%h req=%b, required 1 %h 0",
                     f3, mem_wb_load_valid, mem_wb_rdata, dmem_req, exp);
        end
        step();
    endtask

    task automatic test_misalign();
        logic        rd [3] = '{1'b1, 1'b1, 1'b0};
        logic        wr [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [3] = '{3'b001, 3'b010, 3'b101};
        logic [31:0] ad [3] = '{32'h0000_0101, 32'h0000_0102, 32'h0000_0103};
        for (int i = 0; i < 3; i++) begin
            drive_access(rd[i], wr[i], f3[i], ad[i], 32'h5555_5555);
            @(negedge clk);
            vectors++;
            if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL misalign_accept[%0d]: stall=%b req=%b, required 0 0", i, mem_stall, dmem_req);
            end
            step();
            clear_access();
            @(negedge clk);
            vectors++;
            if ({misalign_fault, access_fault, dmem_req, mem_stall} !== 4'b1000) begin
                miscompares++;
                $display("FAIL misalign_pulse[%0d]: mf=%b af=%b req=%b stall=%b, required 1 0 0 0",
                         i, misalign_fault, access_fault, dmem_req, mem_stall);
            end
            step();
            @(negedge clk);
            vectors++;
            if (misalign_fault !== 1'b0 || dmem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL misalign_end[%0d]: mf=%b req=%b, required 0 0", i, misalign_fault, dmem_req);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        logic       rd [3] = '{1'b1, 1'b1, 1'b0};
        logic       wr [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] f3 [3] = '{3'b010, 3'b011, 3'b110};
        for (int i = 0; i < 3; i++) begin
            drive_access(rd[i], wr[i], f3[i], 32'h0000_0100, 32'h0);
            @(negedge clk);
            vectors++;
            if (mem_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_stall[%0d]: got %b, required 0", i, mem_stall);
            end
            step();
            clear_access();
            @(negedge clk);
            vectors++;
            if ({access_fault, misalign_fault, dmem_req} !== 3'b100) begin
                miscompares++;
                $display("FAIL illegal_pulse[%0d]: af=%b mf=%b req=%b, required 1 0 0",
                         i, access_fault, misalign_fault, dmem_req);
            end
            step();
            @(negedge clk);
            vectors++;
            if (access_fault !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_end[%0d]: af=%b, required 0", i, access_fault);
            end
            step();
        end
    endtask

    // LW granted but never answered: fault after 15 busy cycles.
    task automatic test_timeout();
        int   stall_cnt = 0;
        int   cyc = 1;
        logic seen = 1'b0;
        drive_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        @(negedge clk);
        if (mem_stall === 1'b1) stall_cnt++;
        step();
        clear_access();
        dmem_gnt = 1'b1;
        while (cyc <= 40 && !seen) begin
            @(negedge clk);
            if (access_fault === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (mem_stall === 1'b1) stall_cnt++;
                step();
                dmem_gnt = 1'b0;
                cyc++;
            end
        end
        vectors++;
        if (seen !== 1'b1 || cyc !== 16) begin
            miscompares++;
            $display("FAIL timeout_cycle: seen=%b cycle=%0d, required 1 16", seen, cyc);
        end
        vectors++;
        if (stall_cnt !== 15 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_stall: stall_cycles=%0d stall=%b req=%b, required 15 0 0",
                     stall_cnt, mem_stall, dmem_req);
        end
        step();
        @(negedge clk);
        vectors++;
        if (access_fault !== 1'b0 || mem_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_end: af=%b stall=%b, required 0 0", access_fault, mem_stall);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        // Abort during the request phase.
        drive_access(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h1111_2222);
        @(negedge clk);
        step();
        clear_access();
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_req_before: req=%b, required 1", dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_be !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_req_async: req=%b stall=%b be=%b, required 0 0 0000", dmem_req, mem_stall, dmem_be);
        end
        step();
        rst = 1'b0;
        step();
        // Abort while waiting for read data, then a stale rvalid arrives.
        drive_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(negedge clk);
        step();
        clear_access();
        dmem_gnt = 1'b1;
        @(negedge clk);
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait_before: stall=%b req=%b, required 1 0", mem_stall, dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || mem_wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_wait_async: stall=%b req=%b rdata=%h, required 0 0 00000000",
                     mem_stall, dmem_req, mem_wb_rdata);
        end
        step();
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stale_rvalid: stall=%b req=%b, required 0 0", mem_stall, dmem_req);
        end
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        @(negedge clk);
        vectors++;
        if (mem_wb_load_valid !== 1'b0 || mem_wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_no_load: lv=%b rdata=%h, required 0 00000000", mem_wb_load_valid, mem_wb_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_half();
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_load_direct(3'b001, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001);
        test_load_direct(3'b101, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001);
        test_load_direct(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D);
        test_misalign();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
